// File: rtl/rom_boot_streamer.sv
// ---------------------------------------------------------------------------
// rom_boot_streamer
//
// Host-side initiator for the core's 32-bit ROM boot-load port. A byte
// stream from the board's loader (SPI flash / SD reader) is packed
// little-endian into 32-bit words. Each word is delivered with a 4-phase
// req/ack handshake: raise req, wait for ack, drop req, then wait for ack to
// drop. When NUM_WORDS words have been delivered, the block waits for the
// core to report that the ROM image is initialised.
//
// Ports
//   ck16                  16 MHz system clock
//   reset_n               asynchronous active-low reset
//   start                 1-cycle pulse that begins a load; ignored while busy
//   abort                 level input that cancels the load and returns to IDLE
//   byte_data/_valid      incoming stream byte and its valid qualifier
//   byte_ready            byte accepted when byte_valid & byte_ready
//   host_bootdata         packed word; first byte in [7:0], fourth in [31:24]
//   host_bootdata_req     word request, held until the core acknowledges
//   host_bootdata_ack     core acknowledge, synchronous to ck16
//   host_rom_initialised  core reports that the ROM image is complete
//   busy/done/error       load status flags
//   words_sent            number of completed handshakes
// ---------------------------------------------------------------------------
module rom_boot_streamer #(
   parameter int NUM_WORDS   = 8192,
   parameter int ACK_TIMEOUT = 65535,
   parameter int WCNT_W      = 16
) (
   input  logic              ck16,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [7:0]        byte_data,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic [31:0]       host_bootdata,
   output logic              host_bootdata_req,
   input  logic              host_bootdata_ack,
   input  logic              host_rom_initialised,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [WCNT_W-1:0] words_sent
);

   // The timer only has to reach ACK_TIMEOUT-1.
   localparam int                 TIMER_W     = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
   localparam bit                 TIMEOUT_EN  = (ACK_TIMEOUT != 0);
   localparam logic [WCNT_W-1:0]  WORDS_TOTAL = WCNT_W'(NUM_WORDS);

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      REQ,
      RELEASE,
      WAIT_INIT,
      DONE,
      ERROR
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          idx_q, idx_d;
   logic [31:0]         data_q, data_d;
   logic                req_q, req_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                error_q, error_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;

   logic [WCNT_W-1:0]   wcnt_inc;
   logic                timeout_hit;
   logic                timed_state;

   assign wcnt_inc    = wcnt_q + 1'b1;
   assign timeout_hit = TIMEOUT_EN && (timer_q == TIMER_LAST);
   assign timed_state = (state_q == REQ) || (state_q == RELEASE) || (state_q == WAIT_INIT);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      data_d  = data_q;
      req_d   = req_q;
      done_d  = done_q;
      error_d = error_q;
      wcnt_d  = wcnt_q;

      // abort overrides every other event in the same cycle.
      if (abort && (state_q != IDLE)) begin
         state_d = IDLE;
         req_d   = 1'b0;
         idx_d   = 2'd0;
      end else begin
         case (state_q)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  wcnt_d  = '0;
                  idx_d   = 2'd0;
                  done_d  = 1'b0;
                  error_d = 1'b0;
                  state_d = FILL;
               end
            end
            FILL: begin
               // byte_ready is high for the whole of FILL, so valid alone
               // marks an accepted byte.
               if (byte_valid) begin
                  data_d[8*idx_q +: 8] = byte_data;
                  idx_d                = idx_q + 2'd1;
                  if (idx_q == 2'd3) begin
                     req_d   = 1'b1;
                     state_d = REQ;
                  end
               end
            end
            REQ: begin
               // A genuine ack is preferred over a timeout in the same cycle.
               if (host_bootdata_ack) begin
                  req_d   = 1'b0;
                  state_d = RELEASE;
               end else if (timeout_hit) begin
                  req_d   = 1'b0;
                  error_d = 1'b1;
                  state_d = ERROR;
               end
            end
            RELEASE: begin
               // The next word is only collected after ack drops, so req
               // can never rise while the core still holds ack.
               if (!host_bootdata_ack) begin
                  wcnt_d  = wcnt_inc;
                  state_d = (wcnt_inc == WORDS_TOTAL) ? WAIT_INIT : FILL;
               end else if (timeout_hit) begin
                  error_d = 1'b1;
                  state_d = ERROR;
               end
            end
            WAIT_INIT: begin
               if (host_rom_initialised) begin
                  done_d  = 1'b1;
                  state_d = DONE;
               end else if (timeout_hit) begin
                  error_d = 1'b1;
                  state_d = ERROR;
               end
            end
            default: begin
               req_d   = 1'b0;
               state_d = IDLE;
            end
         endcase
      end

      // The timer restarts on every state change and only runs while
      // waiting on the core.
      if ((state_d != state_q) || !timed_state) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + 1'b1;
      end

      busy_d = !((state_d == IDLE) || (state_d == DONE) || (state_d == ERROR));
   end

   always_ff @(posedge ck16 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         idx_q   <= 2'd0;
         data_q  <= 32'd0;
         req_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         wcnt_q  <= '0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         req_q   <= req_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         error_q <= error_d;
         wcnt_q  <= wcnt_d;
         timer_q <= timer_d;
      end
   end

   assign byte_ready        = (state_q == FILL);
   assign host_bootdata     = data_q;
   assign host_bootdata_req = req_q;
   assign busy              = busy_q;
   assign done              = done_q;
   assign error             = error_q;
   assign words_sent        = wcnt_q;

endmodule

// File: tb/tb_rom_boot_streamer.sv
// ---------------------------------------------------------------------------
// tb_rom_boot_streamer
//
// Directed bench for rom_boot_streamer with NUM_WORDS=2 and ACK_TIMEOUT=16.
// A table of complete two-word loads (byte pattern, byte gap, ack timing,
// expected words) is run back to back. After that, hand-written sequences
// cover ack held high, abort racing ack, timeout and restart, start while
// busy, and asynchronous reset mid-fill. A background process plays the
// core's ack and captures each word when req rises.
// ---------------------------------------------------------------------------
module tb_rom_boot_streamer;
   localparam int NUM_WORDS   = 2;
   localparam int ACK_TIMEOUT = 16;
   localparam int WCNT_W      = 16;

   logic              clk        = 1'b0;
   logic              rst_n      = 1'b0;
   logic              start      = 1'b0;
   logic              abort      = 1'b0;
   logic [7:0]        byte_data  = 8'd0;
   logic              byte_valid = 1'b0;
   logic              rom_init   = 1'b0;
   logic              byte_ready;
   logic [31:0]       bootdata;
   logic              req;
   logic              busy;
   logic              done;
   logic              error;
   logic [WCNT_W-1:0] words_sent;

   logic ack_auto = 1'b1;
   logic ack_resp = 1'b0;
   logic ack_man  = 1'b0;
   logic ack;
   assign ack = ack_auto ? ack_resp : ack_man;

   int ack_delay = 2;
   int ack_hold  = 1;
   int checks    = 0;
   int errors    = 0;
   logic [31:0] cap_q[$];

   always #5 clk = ~clk;

   rom_boot_streamer #(
      .NUM_WORDS  (NUM_WORDS),
      .ACK_TIMEOUT(ACK_TIMEOUT),
      .WCNT_W     (WCNT_W)
   ) dut (
      .ck16                (clk),
      .reset_n             (rst_n),
      .start               (start),
      .abort               (abort),
      .byte_data           (byte_data),
      .byte_valid          (byte_valid),
      .byte_ready          (byte_ready),
      .host_bootdata       (bootdata),
      .host_bootdata_req   (req),
      .host_bootdata_ack   (ack),
      .host_rom_initialised(rom_init),
      .busy                (busy),
      .done                (done),
      .error               (error),
      .words_sent          (words_sent)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Present one byte after 'gap' idle cycles and hold it until accepted.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int k;
      byte_valid = 1'b0;
      repeat (gap) step();
      byte_data  = b;
      byte_valid = 1'b1;
      k = 0;
      while (!byte_ready && k < 300) begin
         step();
         k++;
      end
      if (k >= 300) check("byte_accept_timeout", 32'd1, 32'd0);
      step();
      byte_valid = 1'b0;
   endtask

   task automatic wait_words(input logic [WCNT_W-1:0] n);
      int k;
      k = 0;
      while (words_sent != n && k < 300) begin
         step();
         k++;
      end
      check("words_sent_reached", 32'(words_sent), 32'(n));
   endtask

   // Core model plus word monitor. Sampling at +2 lets every +1 driver settle,
   // so ack_prev is exactly what the DUT sees at the next edge.
   initial begin : core_model
      logic        req_prev;
      logic        ack_prev;
      logic [31:0] held;
      int          rcnt;
      int          hcnt;
      req_prev = 1'b0;
      ack_prev = 1'b0;
      held     = 32'd0;
      rcnt     = 0;
      hcnt     = 0;
      forever begin
         @(posedge clk);
         #2;
         if (rst_n) begin
            if (req && !req_prev) begin
               check("req_rise_while_ack", {31'd0, ack_prev}, 32'd0);
               cap_q.push_back(bootdata);
               held = bootdata;
            end else if (req) begin
               check("word_stable", bootdata, held);
            end
            if (req || ack) check("ready_low_in_handshake", {31'd0, byte_ready}, 32'd0);
            if (ack_auto) begin
               if (req && !ack_resp) begin
                  rcnt++;
                  if (rcnt >= ack_delay) begin
                     ack_resp = 1'b1;
                     rcnt     = 0;
                  end
               end else if (!req && ack_resp) begin
                  hcnt++;
                  if (hcnt >= ack_hold) begin
                     ack_resp = 1'b0;
                     hcnt     = 0;
                  end
               end
            end
         end else begin
            ack_resp = 1'b0;
            rcnt     = 0;
            hcnt     = 0;
         end
         req_prev = req;
         ack_prev = ack_auto ? ack_resp : ack_man;
      end
   end

   typedef struct {
      logic [63:0] bytes;   // byte i of the stream in bits [8i+7:8i]
      int          gap;
      int          delay;
      int          hold;
      logic [31:0] w0;
      logic [31:0] w1;
   } vec_t;

   vec_t vecs[4];

   task automatic run_load(input vec_t v, input int n);
      ack_auto  = 1'b1;
      ack_delay = v.delay;
      ack_hold  = v.hold;
      cap_q.delete();
      pulse_start();
      check("start_busy", {31'd0, busy}, 32'd1);
      check("start_clears_done", {31'd0, done}, 32'd0);
      check("start_clears_error", {31'd0, error}, 32'd0);
      check("start_clears_words", 32'(words_sent), 32'd0);
      for (int i = 0; i < 8; i++) send_byte(v.bytes[8*i +: 8], v.gap);
      wait_words(WCNT_W'(2));
      check("wait_init_busy", {31'd0, busy}, 32'd1);
      check("wait_init_not_done", {31'd0, done}, 32'd0);
      check("word_count", cap_q.size(), 32'd2);
      if (cap_q.size() >= 1) check("word0", cap_q[0], v.w0);
      if (cap_q.size() >= 2) check("word1", cap_q[1], v.w1);
      rom_init = 1'b1;
      step();
      rom_init = 1'b0;
      check("done_set", {31'd0, done}, 32'd1);
      check("done_not_busy", {31'd0, busy}, 32'd0);
      check("done_words", 32'(words_sent), 32'd2);
      $display("load %0d: gap=%0d delay=%0d hold=%0d words=%0d done=%0b",
               n, v.gap, v.delay, v.hold, cap_q.size(), done);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      vecs[0] = '{64'h8877665544332211, 0, 2, 1, 32'h44332211, 32'h88776655};
      vecs[1] = '{64'h8877665544332211, 2, 2, 1, 32'h44332211, 32'h88776655};
      vecs[2] = '{64'hFE7F80015AA5FF00, 1, 1, 2, 32'h5AA5FF00, 32'hFE7F8001};
      vecs[3] = '{64'hBEBAFECAEFBEADDE, 0, 5, 3, 32'hEFBEADDE, 32'hBEBAFECA};

      // Reset state.
      repeat (3) step();
      check("rst_req", {31'd0, req}, 32'd0);
      check("rst_ready", {31'd0, byte_ready}, 32'd0);
      check("rst_data", bootdata, 32'd0);
      check("rst_flags", {29'd0, busy, done, error}, 32'd0);
      check("rst_words", 32'(words_sent), 32'd0);
      #3 rst_n = 1'b1;
      step();
      check("idle_ready", {31'd0, byte_ready}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);

      for (int i = 0; i < 4; i++) run_load(vecs[i], i);

      // Ack held high after req falls: words_sent waits for ack to drop.
      ack_auto = 1'b0;
      ack_man  = 1'b0;
      pulse_start();
      send_byte(8'hA1, 0);
      send_byte(8'hB2, 0);
      send_byte(8'hC3, 0);
      send_byte(8'hD4, 0);
      check("pack_latency_req", {31'd0, req}, 32'd1);
      check("pack_data", bootdata, 32'hD4C3B2A1);
      ack_man = 1'b1;
      step();
      check("req_drop_on_ack", {31'd0, req}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         step();
         check("release_words_held", 32'(words_sent), 32'd0);
         check("release_req_low", {31'd0, req}, 32'd0);
      end
      ack_man = 1'b0;
      step();
      check("release_words_inc", 32'(words_sent), 32'd1);
      check("release_back_to_fill", {31'd0, byte_ready}, 32'd1);
      check("release_no_req", {31'd0, req}, 32'd0);
      $display("seq ack_hold: words_sent=%0d", words_sent);

      // Abort in REQ with ack high in the same cycle.
      send_byte(8'h10, 0);
      send_byte(8'h20, 0);
      send_byte(8'h30, 0);
      send_byte(8'h40, 0);
      check("second_word", bootdata, 32'h40302010);
      check("second_req", {31'd0, req}, 32'd1);
      ack_man = 1'b1;
      abort   = 1'b1;
      step();
      abort   = 1'b0;
      ack_man = 1'b0;
      check("abort_req", {31'd0, req}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_ready", {31'd0, byte_ready}, 32'd0);
      check("abort_words_kept", 32'(words_sent), 32'd1);
      step();
      check("abort_stays_idle", {30'd0, req, busy}, 32'd0);
      $display("seq abort: words_sent=%0d", words_sent);

      // Ack never comes: error after 16 cycles in REQ, then restart.
      pulse_start();
      send_byte(8'h5A, 0);
      send_byte(8'h6B, 0);
      send_byte(8'h7C, 0);
      send_byte(8'h8D, 0);
      check("to_req_start", {31'd0, req}, 32'd1);
      for (int i = 1; i < 16; i++) begin
         step();
         check("to_req_held", {31'd0, req}, 32'd1);
         check("to_no_error_yet", {31'd0, error}, 32'd0);
      end
      step();
      check("to_req_dropped", {31'd0, req}, 32'd0);
      check("to_error", {31'd0, error}, 32'd1);
      check("to_not_busy", {31'd0, busy}, 32'd0);
      ack_auto  = 1'b1;
      ack_delay = 1;
      ack_hold  = 1;
      cap_q.delete();
      pulse_start();
      check("restart_clears_error", {31'd0, error}, 32'd0);
      check("restart_busy", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 8; i++) send_byte(8'(8'h01 + i), 0);
      wait_words(WCNT_W'(2));
      check("restart_count", cap_q.size(), 32'd2);
      if (cap_q.size() >= 2) begin
         check("restart_w0", cap_q[0], 32'h04030201);
         check("restart_w1", cap_q[1], 32'h08070605);
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_wait_init_busy", {31'd0, busy}, 32'd0);
      check("abort_wait_init_words", 32'(words_sent), 32'd2);
      $display("seq timeout: restart words=%0d", cap_q.size());

      // Start while busy is ignored; async reset mid-fill clears everything.
      ack_delay = 2;
      cap_q.delete();
      pulse_start();
      send_byte(8'hC1, 0);
      send_byte(8'hC2, 0);
      pulse_start();
      check("start_ignored_busy", {31'd0, busy}, 32'd1);
      send_byte(8'hC3, 0);
      send_byte(8'hC4, 0);
      check("start_ignored_req", {31'd0, req}, 32'd1);
      check("start_ignored_word", bootdata, 32'hC4C3C2C1);
      send_byte(8'hE1, 0);
      send_byte(8'hE2, 0);
      check("mid_fill_words", 32'(words_sent), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_data", bootdata, 32'd0);
      check("async_rst_ready", {31'd0, byte_ready}, 32'd0);
      check("async_rst_flags", {28'd0, req, busy, done, error}, 32'd0);
      check("async_rst_words", 32'(words_sent), 32'd0);
      step();
      check("rst_held_ready", {31'd0, byte_ready}, 32'd0);
      #3 rst_n = 1'b1;
      step();
      check("post_rst_idle", {30'd0, busy, byte_ready}, 32'd0);
      $display("seq reset: words_sent=%0d busy=%0b", words_sent, busy);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
